// File: rtl/waveform_loader_if.sv
// Byte-stream input and RAM port A bundle for the waveform loader.
interface waveform_loader_if #(
   parameter int ADDR_W = 9,
   parameter int WIDTH  = 24
);
   logic [7:0]        byte_in;
   logic              byte_valid_in;
   logic              byte_ready_out;
   logic [ADDR_W-1:0] ram_addr_out;
   logic [WIDTH-1:0]  ram_din_out;
   logic              ram_we_out;
   logic              ram_en_out;

   // loader side: consumes the byte stream, drives the RAM write port
   modport slave (
      input  byte_in, byte_valid_in,
      output byte_ready_out, ram_addr_out, ram_din_out, ram_we_out, ram_en_out
   );

   // source side: produces bytes, observes the RAM write port
   modport master (
      output byte_in, byte_valid_in,
      input  byte_ready_out, ram_addr_out, ram_din_out, ram_we_out, ram_en_out
   );
endinterface

// File: rtl/waveform_loader.sv
// Waveform table loader: packs a byte stream into 24-bit samples, writes a
// full table through RAM port A and verifies it with a trailing XOR byte.
module waveform_loader #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9,
   parameter int WIDTH  = 24
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              start_in,
   input  logic              abort_in,
   waveform_loader_if.slave  bus,
   output logic              busy_out,
   output logic              done_out,
   output logic              error_out,
   output logic              loaded_out
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RECV  = 3'd1;
   localparam logic [2:0] WRITE = 3'd2;
   localparam logic [2:0] CHECK = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [2:0]        state_q,  state_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [1:0]        cnt_q,    cnt_d;
   logic [15:0]       pend_q,   pend_d;    // first two bytes of the sample in flight
   logic [7:0]        xor_q,    xor_d;
   logic              err_q,    err_d;
   logic              loaded_q, loaded_d;
   logic              ready_q,  ready_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;
   logic              we_q,     we_d;
   logic [ADDR_W-1:0] waddr_q,  waddr_d;
   logic [WIDTH-1:0]  wdata_q,  wdata_d;
   logic              accept;

   // A byte moves only when the registered ready meets valid.
   assign accept = bus.byte_valid_in & ready_q;

   // Next-state logic: start beats abort, both beat any byte handshake.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      xor_d    = xor_q;
      err_d    = err_q;
      loaded_d = loaded_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      done_d   = 1'b0;

      if (start_in) begin
         state_d  = RECV;
         addr_d   = '0;
         cnt_d    = '0;
         pend_d   = '0;
         xor_d    = '0;
         err_d    = 1'b0;
         loaded_d = 1'b0;
      end else if (abort_in && (state_q != IDLE)) begin
         // partial sample is dropped; RAM keeps whatever was written
         state_d  = IDLE;
         cnt_d    = '0;
         pend_d   = '0;
         loaded_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            RECV: begin
               if (accept) begin
                  xor_d = xor_q ^ bus.byte_in;
                  if (cnt_q == 2'd2) begin
                     // third byte completes the sample; present it for one cycle
                     cnt_d   = '0;
                     state_d = WRITE;
                     we_d    = 1'b1;
                     waddr_d = addr_q;
                     wdata_d = {pend_q, bus.byte_in};
                  end else begin
                     cnt_d  = cnt_q + 2'd1;
                     pend_d = {pend_q[7:0], bus.byte_in};
                  end
               end
            end
            WRITE: begin
               if (addr_q == LAST_ADDR) begin
                  state_d = CHECK;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = RECV;
               end
            end
            CHECK: begin
               if (accept) begin
                  state_d  = DONE;
                  done_d   = 1'b1;
                  err_d    = (bus.byte_in != xor_q);
                  loaded_d = (bus.byte_in == xor_q);
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Status flags follow the state being entered so they line up with it.
   always_comb begin
      ready_d = (state_d == RECV) || (state_d == CHECK);
      busy_d  = (state_d != IDLE);
   end

   // State and output registers; reset drops every output at once.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         pend_q   <= '0;
         xor_q    <= '0;
         err_q    <= 1'b0;
         loaded_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         xor_q    <= xor_d;
         err_q    <= err_d;
         loaded_q <= loaded_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign bus.byte_ready_out = ready_q;
   assign bus.ram_addr_out   = waddr_q;
   assign bus.ram_din_out    = wdata_q;
   assign bus.ram_we_out     = we_q;
   assign bus.ram_en_out     = we_q;
   assign busy_out           = busy_q;
   assign done_out           = done_q;
   assign error_out          = err_q;
   assign loaded_out         = loaded_q;

endmodule
